// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between p_NUM_REQ byte requesters.
// It latches one byte per grant, starts the frame, then waits for completion or the watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame in flight; arbitrate among i_Req every cycle
// S_START | one-cycle start pulse to the serialiser, ack to the grantee
// S_WAIT  | frame on the line; watchdog running until i_Tx_Done
// S_GAP   | p_GAP_CLKS idle clocks before arbitration resumes
module uart_tx_arbiter #(
    parameter int p_NUM_REQ      = 4,
    parameter int p_CLKs_PB      = 217,
    parameter int p_TIMEOUT_CLKS = 12 * p_CLKs_PB,
    parameter int p_GAP_CLKS     = 2
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic [p_NUM_REQ-1:0]         i_Req,
    input  logic [8*p_NUM_REQ-1:0]       i_Req_Bytes,
    output logic [p_NUM_REQ-1:0]         o_Ack,
    output logic [p_NUM_REQ-1:0]         o_Done,
    output logic                         o_Timeout,
    output logic [7:0]                   o_Tx_Byte,
    output logic                         o_Tx_Start,
    input  logic                         i_Tx_Done,
    output logic                         o_Busy,
    output logic [$clog2(p_NUM_REQ)-1:0] o_Grant_Id
);

    localparam int LP_ID_W  = $clog2(p_NUM_REQ);
    localparam int LP_WD_W  = $clog2(p_TIMEOUT_CLKS + 1);
    localparam int LP_GAP_W = (p_GAP_CLKS > 0) ? $clog2(p_GAP_CLKS + 1) : 1;

    localparam logic [LP_ID_W:0]    LP_N        = (LP_ID_W + 1)'(p_NUM_REQ);
    localparam logic [LP_ID_W-1:0]  LP_PTR_RST  = LP_ID_W'(p_NUM_REQ - 1);
    localparam logic [LP_WD_W-1:0]  LP_WD_LAST  = LP_WD_W'(p_TIMEOUT_CLKS - 1);
    localparam logic [LP_GAP_W-1:0] LP_GAP_LAST = LP_GAP_W'((p_GAP_CLKS > 0) ? p_GAP_CLKS - 1 : 0);

    // Elaboration-time guard on the parameter ranges this block is built for.
    if (p_NUM_REQ < 2 || p_NUM_REQ > 8 || p_CLKs_PB < 1 || p_TIMEOUT_CLKS < 1 || p_GAP_CLKS < 0) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [LP_ID_W-1:0]    r_ptr;
    logic [LP_ID_W-1:0]    r_grant;
    logic [7:0]            r_tx_byte;
    logic [LP_WD_W-1:0]    r_wdog;
    logic [LP_GAP_W-1:0]   r_gap;
    logic [p_NUM_REQ-1:0]  r_done;
    logic                  r_timeout;
    logic                  w_found;
    logic [LP_ID_W-1:0]    w_win;
    logic [LP_ID_W:0]      w_sum;
    logic                  w_frame_end;
    logic [p_NUM_REQ-1:0]  w_ack;
    logic [7:0]            w_req_byte [p_NUM_REQ];

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    for (genvar g = 0; g < p_NUM_REQ; g++) begin : g_bytes
        assign w_req_byte[g] = i_Req_Bytes[8*g +: 8];
    end

    // Search upward from the slot after the last grantee, wrapping at p_NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_sum   = '0;
        for (int k = 1; k <= p_NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (LP_ID_W + 1)'(k);
            if (w_sum >= LP_N) begin
                w_sum = w_sum - LP_N;
            end
            if (!w_found && i_Req[w_sum[LP_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[LP_ID_W-1:0];
            end
        end
    end

    assign w_frame_end = (r_state == S_WAIT) && (i_Tx_Done || (r_wdog == LP_WD_LAST));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_frame_end) begin
                    w_next = (p_GAP_CLKS > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == LP_GAP_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ack = '0;
        if (r_state == S_START) begin
            w_ack[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= LP_PTR_RST;
            r_grant   <= '0;
            r_tx_byte <= 8'h00;
            r_wdog    <= '0;
            r_gap     <= '0;
            r_done    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= '0;
            r_timeout <= 1'b0;

            if (r_state == S_IDLE && w_found) begin
                r_ptr     <= w_win;
                r_grant   <= w_win;
                r_tx_byte <= w_req_byte[w_win];
            end

            if (r_state == S_START) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + LP_WD_W'(1);
            end

            // A completion strobe on the expiry cycle counts as a good frame.
            if (w_frame_end) begin
                if (i_Tx_Done) begin
                    r_done[r_grant] <= 1'b1;
                end else begin
                    r_timeout <= 1'b1;
                end
            end

            if (r_state == S_GAP) begin
                r_gap <= r_gap + LP_GAP_W'(1);
            end else begin
                r_gap <= '0;
            end
        end
    end

    assign o_Ack      = w_ack;
    assign o_Done     = r_done;
    assign o_Timeout  = r_timeout;
    assign o_Tx_Byte  = r_tx_byte;
    assign o_Tx_Start = (r_state == S_START);
    assign o_Busy     = (r_state != S_IDLE);
    assign o_Grant_Id = r_grant;

endmodule
